// File: rtl/multicore_launch_ctrl.sv
// Command-driven launch/teardown sequencer for an N-core cluster:
// IRAM/DRAM loading, bounded run, and DRAM dump streaming.
module multicore_launch_ctrl #(
  parameter int N_CORES    = 8,
  parameter int CORE_W     = 3,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CORE_W-1:0] cmd_core,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [N_CORES-1:0] iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_wdata,
  output logic              dram_ext_sel,
  output logic              dram_ext_we,
  output logic              dram_ext_re,
  output logic [ADDR_W-1:0] dram_ext_addr,
  output logic [DATA_W-1:0] dram_ext_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              core_start,
  input  logic [N_CORES-1:0] core_halt,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [CYC_W-1:0]  run_cycles,
  output logic              timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LDI   = 3'd1;
  localparam logic [2:0] S_LDD   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DREQ  = 3'd4;
  localparam logic [2:0] S_DWAIT = 3'd5;
  localparam logic [2:0] S_DOUT  = 3'd6;

  localparam logic [1:0] OP_LDI = 2'd0;
  localparam logic [1:0] OP_LDD = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;

  localparam logic [CYC_W-1:0] LP_TMO_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [ADDR_W:0]  LP_CNT_ONE  = (ADDR_W+1)'(1);

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic [ADDR_W:0]    r_cnt;
  logic [CORE_W-1:0]  r_core;
  logic [N_CORES-1:0] r_iram_we;
  logic [ADDR_W-1:0]  r_iram_addr;
  logic [DATA_W-1:0]  r_iram_wdata;
  logic               r_dram_we;
  logic               r_dram_re;
  logic [ADDR_W-1:0]  r_dram_addr;
  logic [DATA_W-1:0]  r_dram_wdata;
  logic [DATA_W-1:0]  r_rd_data;
  logic [CYC_W-1:0]   r_run_cycles;
  logic               r_timeout;

  logic w_load;
  logic w_wr_fire;
  logic w_core_ok;
  logic w_all_halt;
  logic w_tmo;

  assign w_load     = (r_state == S_LDI) || (r_state == S_LDD);
  assign wr_ready   = w_load && (r_cnt != '0);
  assign w_wr_fire  = wr_ready && wr_valid;
  assign w_core_ok  = int'(cmd_core) < N_CORES;
  assign w_all_halt = &core_halt;
  assign w_tmo      = (MAX_CYCLES != 0) && (r_run_cycles == LP_TMO_LAST);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_core       <= '0;
      r_iram_we    <= '0;
      r_iram_addr  <= '0;
      r_iram_wdata <= '0;
      r_dram_we    <= 1'b0;
      r_dram_re    <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_wdata <= '0;
      r_rd_data    <= '0;
      r_run_cycles <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_iram_we <= '0;
      r_dram_we <= 1'b0;
      r_dram_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_ptr  <= cmd_base;
            r_cnt  <= cmd_len;
            r_core <= cmd_core;
            if (cmd_len != '0) begin
              case (cmd_op)
                OP_LDI: if (w_core_ok) r_state <= S_LDI;
                OP_LDD: r_state <= S_LDD;
                OP_RUN: begin
                  r_state      <= S_RUN;
                  r_run_cycles <= '0;
                  r_timeout    <= 1'b0;
                end
                default: begin
                  r_state     <= S_DREQ;
                  r_dram_re   <= 1'b1;
                  r_dram_addr <= cmd_base;
                  r_ptr       <= cmd_base + ADDR_W'(1);
                end
              endcase
            end
          end
        end
        S_LDI, S_LDD: begin
          // Stay one extra cycle after the last word so its strobe is seen.
          if (w_wr_fire) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_cnt <= r_cnt - LP_CNT_ONE;
            if (r_state == S_LDI) begin
              r_iram_we    <= N_CORES'(1) << r_core;
              r_iram_addr  <= r_ptr;
              r_iram_wdata <= wr_data;
            end else begin
              r_dram_we    <= 1'b1;
              r_dram_addr  <= r_ptr;
              r_dram_wdata <= wr_data;
            end
          end else if (r_cnt == '0) begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_run_cycles != '1)
            r_run_cycles <= r_run_cycles + CYC_W'(1);
          if (w_all_halt) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end
        end
        S_DREQ: r_state <= S_DWAIT;
        S_DWAIT: begin
          r_rd_data <= dram_rdata;
          r_state   <= S_DOUT;
        end
        S_DOUT: begin
          if (rd_ready) begin
            r_cnt <= r_cnt - LP_CNT_ONE;
            if (r_cnt > LP_CNT_ONE) begin
              r_state     <= S_DREQ;
              r_dram_re   <= 1'b1;
              r_dram_addr <= r_ptr;
              r_ptr       <= r_ptr + ADDR_W'(1);
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign core_start     = (r_state == S_RUN);
  assign rd_valid       = (r_state == S_DOUT);
  assign dram_ext_sel   = (r_state == S_LDD) || (r_state == S_DREQ) ||
                          (r_state == S_DWAIT) || (r_state == S_DOUT);
  assign iram_we        = r_iram_we;
  assign iram_addr      = r_iram_addr;
  assign iram_wdata     = r_iram_wdata;
  assign dram_ext_we    = r_dram_we;
  assign dram_ext_re    = r_dram_re;
  assign dram_ext_addr  = r_dram_addr;
  assign dram_ext_wdata = r_dram_wdata;
  assign rd_data        = r_rd_data;
  assign run_cycles     = r_run_cycles;
  assign timeout        = r_timeout;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// Directed bench for multicore_launch_ctrl: write/dump scoreboards,
// run-cycle model, and a second instance with a 50-cycle timeout.
module tb_multicore_launch_ctrl;
  localparam int N  = 8;
  localparam int CW = 3;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int YW = 32;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic          cmd_valid = 1'b0, cmd_valid_t = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [CW-1:0] cmd_core = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [N-1:0]  core_halt = '0;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] dram_rdata = '0;

  logic          cmd_ready, wr_ready, dram_ext_sel, dram_ext_we, dram_ext_re;
  logic [N-1:0]  iram_we;
  logic [AW-1:0] iram_addr, dram_ext_addr;
  logic [DW-1:0] iram_wdata, dram_ext_wdata, rd_data;
  logic          core_start, rd_valid, busy, timeout;
  logic [YW-1:0] run_cycles;

  logic          t_cmd_ready, t_wr_ready, t_sel, t_we, t_re;
  logic [N-1:0]  t_iram_we;
  logic [AW-1:0] t_iram_addr, t_dram_addr;
  logic [DW-1:0] t_iram_wdata, t_dram_wdata, t_rd_data;
  logic          t_core_start, t_rd_valid, t_busy, t_timeout;
  logic [YW-1:0] t_run_cycles;

  multicore_launch_ctrl #(.N_CORES(N), .CORE_W(CW), .ADDR_W(AW),
    .DATA_W(DW), .CYC_W(YW), .MAX_CYCLES(0)) u_dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_core(cmd_core), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .dram_ext_sel(dram_ext_sel), .dram_ext_we(dram_ext_we),
    .dram_ext_re(dram_ext_re), .dram_ext_addr(dram_ext_addr),
    .dram_ext_wdata(dram_ext_wdata), .dram_rdata(dram_rdata),
    .core_start(core_start), .core_halt(core_halt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .run_cycles(run_cycles), .timeout(timeout));

  multicore_launch_ctrl #(.N_CORES(N), .CORE_W(CW), .ADDR_W(AW),
    .DATA_W(DW), .CYC_W(YW), .MAX_CYCLES(50)) u_tmo (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid_t), .cmd_ready(t_cmd_ready), .cmd_op(cmd_op),
    .cmd_core(cmd_core), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(1'b0), .wr_ready(t_wr_ready), .wr_data(wr_data),
    .iram_we(t_iram_we), .iram_addr(t_iram_addr), .iram_wdata(t_iram_wdata),
    .dram_ext_sel(t_sel), .dram_ext_we(t_we),
    .dram_ext_re(t_re), .dram_ext_addr(t_dram_addr),
    .dram_ext_wdata(t_dram_wdata), .dram_rdata(16'h0),
    .core_start(t_core_start), .core_halt(core_halt),
    .rd_valid(t_rd_valid), .rd_ready(1'b0), .rd_data(t_rd_data),
    .busy(t_busy), .run_cycles(t_run_cycles), .timeout(t_timeout));

  int n_tests = 0;
  int n_fail  = 0;
  int n_iw = 0, n_dw = 0, n_rd = 0;
  bit armed = 1'b0;

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] model_mem [0:511];
  logic [DW-1:0] iram [0:N-1][0:511];

  int            qi_core[$];
  logic [AW-1:0] qi_addr[$], qd_addr[$];
  logic [DW-1:0] qi_data[$], qd_data[$], qr_data[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // DRAM port-0 and IRAM models
  always @(posedge clock) begin
    if (dram_ext_sel && dram_ext_we) mem[dram_ext_addr] <= dram_ext_wdata;
    if (dram_ext_re) dram_rdata <= mem[dram_ext_addr];
    for (int k = 0; k < N; k++)
      if (iram_we[k]) iram[k][iram_addr] <= iram_wdata;
  end

  logic [YW-1:0] m_run = '0;
  logic          prev_start = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;

  always @(negedge clock) begin
    int c;
    if (armed) begin
      chk("ready_vs_busy", cmd_ready, !busy);
      chk("we_re_excl", dram_ext_we & dram_ext_re, 0);
      chk("timeout_off", timeout, 0);
      chk("t_ready_vs_busy", t_cmd_ready, !t_busy);
      if (|iram_we) begin
        n_iw++;
        if (qi_addr.size() == 0) chk("iram_spurious", iram_we, 0);
        else begin
          c = qi_core.pop_front();
          chk("iram_we", iram_we, N'(1) << c);
          chk("iram_addr", iram_addr, qi_addr.pop_front());
          chk("iram_data", iram_wdata, qi_data.pop_front());
        end
      end
      if (dram_ext_we) begin
        n_dw++;
        chk("dram_sel_wr", dram_ext_sel, 1);
        if (qd_addr.size() == 0) chk("dram_spurious", dram_ext_we, 0);
        else begin
          chk("dram_addr", dram_ext_addr, qd_addr.pop_front());
          chk("dram_data", dram_ext_wdata, qd_data.pop_front());
        end
      end
      if (core_start) chk("sel_in_run", dram_ext_sel, 0);
      if (!rst_n) m_run = '0;
      else begin
        if (core_start && !prev_start) m_run = '0;
        chk("run_cycles", run_cycles, m_run);
        if (core_start && m_run != '1) m_run = m_run + 1;
      end
      if (rd_valid && prev_v && !prev_r) chk("rd_stable", rd_data, prev_d);
      if (rd_valid && rd_ready) begin
        n_rd++;
        if (qr_data.size() == 0) chk("rd_spurious", rd_valid, 0);
        else chk("rd_data", rd_data, qr_data.pop_front());
      end
    end
    prev_start = core_start;
    prev_v = rd_valid;
    prev_r = rd_ready;
    prev_d = rd_data;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!cmd_ready && t < 50) begin tick(); t++; end
    chk("idle_reached", cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input int core,
                          input int base, input int len, input bit tmo);
    int t;
    t = 0;
    while (!(tmo ? t_cmd_ready : cmd_ready) && t < 50) begin tick(); t++; end
    chk("cmd_ready_wait", tmo ? t_cmd_ready : cmd_ready, 1);
    cmd_op = op;
    cmd_core = CW'(core);
    cmd_base = AW'(base);
    cmd_len = (AW+1)'(len);
    if (tmo) cmd_valid_t = 1'b1;
    else cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_valid_t = 1'b0;
  endtask

  task automatic feed_word(input logic [1:0] op, input int core,
                           input int a, input logic [DW-1:0] d);
    int t;
    t = 0;
    wr_valid = 1'b1;
    wr_data = d;
    while (!wr_ready && t < 20) begin tick(); t++; end
    chk("wr_ready", wr_ready, 1);
    if (op == 2'd0) begin
      qi_core.push_back(core);
      qi_addr.push_back(AW'(a));
      qi_data.push_back(d);
    end else begin
      chk("sel_load", dram_ext_sel, 1);
      qd_addr.push_back(AW'(a));
      qd_data.push_back(d);
      model_mem[AW'(a)] = d;
    end
    tick();
  endtask

  task automatic load(input logic [1:0] op, input int core, input int base,
                      input int len, input logic [DW-1:0] d0,
                      input logic [DW-1:0] step, input int bubble);
    send_cmd(op, core, base, len, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (i == bubble) begin wr_valid = 1'b0; tick(); end
      feed_word(op, core, base + i, d0 + DW'(i) * step);
    end
    wr_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0]  h;
    logic [DW-1:0] v;
    int t, cnt, n0;
    for (int i = 0; i < 512; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_iram_we", iram_we, 0);
    chk("rst_dram_we", dram_ext_we, 0);
    chk("rst_dram_re", dram_ext_re, 0);
    chk("rst_sel", dram_ext_sel, 0);
    chk("rst_start", core_start, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_addr", dram_ext_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    armed = 1'b1;

    load(2'd0, 5, 'h000, 4, 16'h1111, 16'h1111, 2);
    tick();
    chk("iram_strobes", n_iw, 4);
    chk("iram5_w0", iram[5][0], 16'h1111);
    chk("iram5_w3", iram[5][3], 16'h4444);

    load(2'd1, 0, 'h1FE, 4, 16'hA001, 16'h0001, -1);
    tick();
    chk("wrap_1fe", mem['h1FE], 16'hA001);
    chk("wrap_1ff", mem['h1FF], 16'hA002);
    chk("wrap_000", mem['h000], 16'hA003);
    chk("wrap_001", mem['h001], 16'hA004);

    send_cmd(2'd1, 0, 'h020, 5, 1'b0);
    for (int i = 0; i < 3; i++) feed_word(2'd1, 0, 'h20 + i, 16'hC000 + DW'(i));
    wr_valid = 1'b1;
    wr_data = 16'hC003;
    rst_n = 1'b0;
    tick();
    chk("midrst_dram_we", dram_ext_we, 0);
    chk("midrst_iram_we", iram_we, 0);
    chk("midrst_sel", dram_ext_sel, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_wr_ready", wr_ready, 0);
    rst_n = 1'b1;
    wr_valid = 1'b0;
    tick(); tick();
    chk("midrst_w2", mem['h022], 16'hC002);
    chk("midrst_w3", mem['h023], 16'h0000);

    send_cmd(2'd2, 0, 0, 1, 1'b0);
    for (int c = 1; c <= 80; c++) begin
      h = '0;
      for (int k = 0; k < N; k++) if (10 * (k + 1) <= c) h[k] = 1'b1;
      core_halt = h;
      if (c == 80) chk("run_start_high", core_start, 1);
      tick();
    end
    chk("run_start_low", core_start, 0);
    chk("run_80", run_cycles, 80);
    chk("run_no_tmo", timeout, 0);
    core_halt = '0;

    core_halt = 8'hF7;
    send_cmd(2'd2, 0, 0, 1, 1'b1);
    cnt = 0;
    while (t_core_start && cnt < 200) begin cnt++; tick(); end
    chk("tmo_cycles_seen", cnt, 50);
    chk("tmo_run_cycles", t_run_cycles, 50);
    chk("tmo_flag", t_timeout, 1);
    chk("tmo_start_low", t_core_start, 0);
    core_halt = '0;

    load(2'd1, 0, 'h010, 3, 16'h5A01, 16'h0101, -1);
    for (int w = 0; w < 3; w++) qr_data.push_back(model_mem['h10 + w]);
    send_cmd(2'd3, 0, 'h010, 3, 1'b0);
    rd_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      t = 0;
      while (!rd_valid && t < 20) begin tick(); t++; end
      chk("rd_valid_wait", rd_valid, 1);
      if (w == 1) begin
        v = rd_data;
        repeat (4) begin
          tick();
          chk("stall_valid", rd_valid, 1);
          chk("stall_data", rd_data, v);
        end
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    wait_idle();
    chk("rd_handshakes", n_rd, 3);

    n0 = n_dw;
    send_cmd(2'd1, 0, 'h030, 0, 1'b0);
    chk("len0_ready", cmd_ready, 1);
    chk("len0_busy", busy, 0);
    repeat (3) tick();
    chk("len0_no_writes", n_dw, n0);

    chk("qi_empty", qi_addr.size(), 0);
    chk("qd_empty", qd_addr.size(), 0);
    chk("qr_empty", qr_data.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
